// File: rtl/sev_mem_crypt_pkg.sv
// Shared types and helpers for the SEV memory encryption engine.
// Key entries are sized for the widest supported DATA_W and truncated at use.
package sev_pkg;

  localparam int unsigned KEY_W_MAX = 512;
  localparam int unsigned ASID_HOST = 0;

  typedef struct packed {
    logic                 valid;
    logic [KEY_W_MAX-1:0] key;
  } asid_t;

  // Rotate the low w bits of v left by sh (sh < w); bits of v above w must be zero.
  function automatic logic [KEY_W_MAX-1:0] rotl(input logic [KEY_W_MAX-1:0] v,
                                                input int unsigned          sh,
                                                input int unsigned          w);
    logic [KEY_W_MAX-1:0] mask;
    mask = (KEY_W_MAX'(1) << w) - KEY_W_MAX'(1);
    return ((v << sh) | (v >> (w - sh))) & mask;
  endfunction

endpackage

// File: rtl/sev_mem_crypt_if.sv
// Request/response handshake bundle between the L2/memory-controller path and the engine.
// master = requester side, slave = encryption engine.
interface sev_mem_crypt_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 48,
  parameter int unsigned ASID_W = 4,
  parameter int unsigned TAG_W  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [ASID_W-1:0] req_asid;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [TAG_W-1:0]  req_tag;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic              resp_err;

  modport master (
    output req_valid, req_asid, req_addr, req_data, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag, resp_err
  );

  modport slave (
    input  req_valid, req_asid, req_addr, req_data, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag, resp_err
  );
endinterface

// File: rtl/sev_mem_crypt_key_table.sv
// Per-ASID key register file: one asynchronous read port, one write/invalidate port.
// Invalidate wins over a simultaneous write, but the key data is still stored.
module sev_key_table
  import sev_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ASID_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              inv_i,
  input  logic [ASID_W-1:0] idx_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ASID_W-1:0] rd_idx_i,
  output asid_t             rd_entry_o
);

  localparam int unsigned N = 2**ASID_W;

  logic [DATA_W-1:0] key_q [N];
  logic [DATA_W-1:0] key_d [N];
  logic [N-1:0]      valid_q;
  logic [N-1:0]      valid_d;

  // NOTE: every comb output takes its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    key_d   = key_q;
    valid_d = valid_q;
    if (we_i) begin
      key_d[idx_i]   = data_i;
      valid_d[idx_i] = 1'b1;
    end
    if (inv_i) valid_d[idx_i] = 1'b0;
  end

  // NOTE: keys are reset so a previous tenant's secrets never survive reset; this rules out RAM macros.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_q   <= '{default: '0};
      valid_q <= '0;
    end else begin
      // NOTE: state uses non-blocking assignment so all flops update from pre-edge values.
      key_q   <= key_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    rd_entry_o.valid = valid_q[rd_idx_i];
    rd_entry_o.key   = KEY_W_MAX'(key_q[rd_idx_i]);
  end

endmodule

// File: rtl/sev_mem_crypt.sv
// Two-stage SEV-style memory encryption engine: S1 looks up the ASID key, S2 applies the keystream.
// Define SEV_ERR_CNT_EN to add the saturating error-response counter err_cnt_o.
module sev_mem_crypt
  import sev_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 48,
  parameter int unsigned ASID_W = 4,
  parameter int unsigned TAG_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              key_we_i,
  input  logic              key_inv_i,
  input  logic [ASID_W-1:0] key_idx_i,
  input  logic [DATA_W-1:0] key_data_i,
  sev_mem_crypt_if.slave    bus
`ifdef SEV_ERR_CNT_EN
  ,
  output logic [15:0]       err_cnt_o
`endif
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  asid_t rd_entry;

  sev_key_table #(.DATA_W(DATA_W), .ASID_W(ASID_W)) u_key_table (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (key_we_i),
    .inv_i     (key_inv_i),
    .idx_i     (key_idx_i),
    .data_i    (key_data_i),
    .rd_idx_i  (bus.req_asid),
    .rd_entry_o(rd_entry)
  );

  logic              s1_valid_q, s1_valid_d;
  logic              s1_host_q,  s1_host_d;
  asid_t             s1_entry_q, s1_entry_d;
  logic [ADDR_W-1:0] s1_addr_q,  s1_addr_d;
  logic [DATA_W-1:0] s1_data_q,  s1_data_d;
  logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;

  logic              s2_valid_q,  s2_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [TAG_W-1:0]  resp_tag_q,  resp_tag_d;
  logic              resp_err_q,  resp_err_d;

  logic              s1_adv;
  logic              accept;
  logic              s1_err;
  logic [DATA_W-1:0] ks;

  // Ready depends only on pipeline state and resp_ready, never on req_valid.
  assign s1_adv        = !s2_valid_q || bus.resp_ready;
  assign bus.req_ready = !s1_valid_q || s1_adv;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_host_d  = s1_host_q;
    s1_entry_d = s1_entry_q;
    s1_addr_d  = s1_addr_q;
    s1_data_d  = s1_data_q;
    s1_tag_d   = s1_tag_q;
    if (bus.req_ready) s1_valid_d = bus.req_valid;
    if (accept) begin
      s1_host_d  = (bus.req_asid == ASID_W'(ASID_HOST));
      s1_entry_d = rd_entry;
      s1_addr_d  = bus.req_addr;
      s1_data_d  = bus.req_data;
      s1_tag_d   = bus.req_tag;
    end
  end

  always_comb begin
    s1_err = !s1_host_q && !s1_entry_q.valid;
    ks     = DATA_W'(rotl(s1_entry_q.key, 32'(s1_addr_q[SH_W-1:0]), DATA_W)) ^ DATA_W'(s1_addr_q);

    s2_valid_d  = s2_valid_q;
    resp_data_d = resp_data_q;
    resp_tag_d  = resp_tag_q;
    resp_err_d  = resp_err_q;
    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        resp_err_d  = s1_err;
        resp_tag_d  = s1_tag_q;
        // Errored requests return zeros so ciphertext never leaves the engine.
        resp_data_d = s1_err    ? '0 :
                      s1_host_q ? s1_data_q : (s1_data_q ^ ks);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_host_q   <= 1'b0;
      s1_entry_q  <= '0;
      s1_addr_q   <= '0;
      s1_data_q   <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      resp_data_q <= '0;
      resp_tag_q  <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_host_q   <= s1_host_d;
      s1_entry_q  <= s1_entry_d;
      s1_addr_q   <= s1_addr_d;
      s1_data_q   <= s1_data_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      resp_data_q <= resp_data_d;
      resp_tag_q  <= resp_tag_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign bus.resp_valid = s2_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_tag   = resp_tag_q;
  assign bus.resp_err   = resp_err_q;

`ifdef SEV_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (s2_valid_q && bus.resp_ready && resp_err_q && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_sev_mem_crypt.sv
// Directed self-checking bench for sev_mem_crypt (DATA_W=64, ADDR_W=48, ASID_W=4, TAG_W=8).
// Inputs change on the falling edge; outputs are sampled 1ns after it.
`timescale 1ns/1ps
module tb_sev_mem_crypt;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 48;
  localparam int ASID_W = 4;
  localparam int TAG_W  = 8;
  localparam logic [63:0] K1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'hFEDCBA9876543210;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_we = 1'b0;
  logic        key_inv = 1'b0;
  logic [3:0]  key_idx = '0;
  logic [63:0] key_data = '0;
`ifdef SEV_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  sev_mem_crypt_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ASID_W(ASID_W), .TAG_W(TAG_W)) bus ();

  sev_mem_crypt #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ASID_W(ASID_W), .TAG_W(TAG_W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .key_we_i  (key_we),
    .key_inv_i (key_inv),
    .key_idx_i (key_idx),
    .key_data_i(key_data),
    .bus       (bus)
`ifdef SEV_ERR_CNT_EN
    ,
    .err_cnt_o (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic write_key(input logic [3:0] idx, input logic [63:0] k, input logic we, input logic inv);
    @(negedge clk);
    key_we = we; key_inv = inv; key_idx = idx; key_data = k;
    @(negedge clk);
    key_we = 1'b0; key_inv = 1'b0;
  endtask

  // One request with resp_ready held high; lat = edges from accept to resp_valid, -1 on timeout.
  task automatic do_req(input logic [3:0] asid, input logic [47:0] addr, input logic [63:0] data,
                        input logic [7:0] tag, output logic [63:0] rdata, output logic [7:0] rtag,
                        output logic rerr, output int lat);
    int n;
    lat = -1; rdata = '0; rtag = '0; rerr = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_asid = asid; bus.req_addr = addr;
    bus.req_data = data; bus.req_tag = tag; bus.resp_ready = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (bus.req_ready) begin
      @(posedge clk);
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        if (bus.resp_valid) begin
          rdata = bus.resp_data; rtag = bus.resp_tag; rerr = bus.resp_err; lat = c;
          break;
        end
      end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_asid = '0; bus.req_addr = '0;
    bus.req_data = '0; bus.req_tag = '0; bus.resp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
    checks++; if (bus.resp_data !== 64'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", bus.resp_data); end
    checks++; if (bus.resp_tag !== 8'h0) begin errors++; $display("FAIL reset_resp_tag: got %h expected 0", bus.resp_tag); end
    checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", bus.resp_err); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_encrypt();
    logic [63:0] d; logic [7:0] t; logic e; int lat;
    write_key(4'd1, K1, 1'b1, 1'b0);
    do_req(4'd1, 48'h0, 64'h0, 8'h11, d, t, e, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL enc_latency: got %0d expected 2", lat); end
    checks++; if (d !== K1) begin errors++; $display("FAIL enc_data: got %h expected %h", d, K1); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL enc_err: got %b expected 0", e); end
    checks++; if (t !== 8'h11) begin errors++; $display("FAIL enc_tag: got %h expected 11", t); end
  endtask

  task automatic test_involution();
    logic [63:0] d, d2; logic [7:0] t; logic e; int lat;
    do_req(4'd1, 48'h10, 64'h0, 8'h12, d, t, e, lat);
    checks++; if (d !== 64'h456789ABCDEF0133) begin errors++; $display("FAIL tweak_data: got %h expected 456789abcdef0133", d); end
    do_req(4'd1, 48'h10, 64'h456789ABCDEF0133, 8'h13, d2, t, e, lat);
    checks++; if (d2 !== 64'h0) begin errors++; $display("FAIL involution_data: got %h expected 0", d2); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL involution_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_host_err();
    logic [63:0] d; logic [7:0] t; logic e; int lat;
    write_key(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    do_req(4'd0, 48'h1234, 64'hDEADBEEF00000000, 8'h21, d, t, e, lat);
    checks++; if (d !== 64'hDEADBEEF00000000) begin errors++; $display("FAIL host_data: got %h expected deadbeef00000000", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL host_err: got %b expected 0", e); end
    do_req(4'd2, 48'h40, 64'h5555_5555_5555_5555, 8'h22, d, t, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL nokey_err: got %b expected 1", e); end
    checks++; if (d !== 64'h0) begin errors++; $display("FAIL nokey_data: got %h expected 0", d); end
    checks++; if (t !== 8'h22) begin errors++; $display("FAIL nokey_tag: got %h expected 22", t); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rq_data [8];
    logic [63:0] exp_data [8];
    int sent, rcv, stall_acc, last_cyc;
    for (int i = 0; i < 8; i++) begin
      rq_data[i]  = 64'h1000 + 64'(i);
      exp_data[i] = (i % 2 == 0) ? (K1 ^ rq_data[i]) : rq_data[i];
    end
    sent = 0; rcv = 0; stall_acc = 0; last_cyc = -1;
    for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
      @(negedge clk);
      bus.resp_ready = (cyc >= 5);
      bus.req_valid  = (sent < 8);
      if (sent < 8) begin
        bus.req_asid = (sent % 2 == 0) ? 4'd1 : 4'd0;
        bus.req_addr = (sent % 2 == 0) ? 48'h0 : 48'(sent * 8);
        bus.req_data = rq_data[sent];
        bus.req_tag  = 8'(8'h40 + sent);
      end
      #1;
      if (cyc >= 2 && cyc < 5) begin
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready cyc%0d: got %b expected 0", cyc, bus.req_ready); end
      end
      if (bus.resp_valid && rcv < 8) begin
        checks++;
        if (bus.resp_data !== exp_data[rcv] || bus.resp_tag !== 8'(8'h40 + rcv) || bus.resp_err !== 1'b0) begin
          errors++;
          $display("FAIL b2b_resp%0d cyc%0d: got data=%h tag=%h err=%b expected data=%h tag=%h err=0",
                   rcv, cyc, bus.resp_data, bus.resp_tag, bus.resp_err, exp_data[rcv], 8'(8'h40 + rcv));
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        sent++;
        if (cyc < 5) stall_acc++;
      end
      if (bus.resp_valid && bus.resp_ready) begin
        rcv++;
        last_cyc = cyc;
      end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++; if (stall_acc !== 2) begin errors++; $display("FAIL b2b_stall_accepts: got %0d expected 2", stall_acc); end
    checks++; if (rcv !== 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", rcv); end
    checks++; if (last_cyc !== 12) begin errors++; $display("FAIL b2b_last_cycle: got %0d expected 12", last_cyc); end
  endtask

  task automatic test_key_update();
    logic [63:0] d; logic [7:0] t; logic e; int lat;
    logic got;
    @(negedge clk);
    key_we = 1'b1; key_idx = 4'd1; key_data = K2;
    bus.req_valid = 1'b1; bus.req_asid = 4'd1; bus.req_addr = 48'h0;
    bus.req_data = 64'h0; bus.req_tag = 8'h31; bus.resp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL kupd_ready: got %b expected 1", bus.req_ready); end
    @(negedge clk);
    key_we = 1'b0; bus.req_valid = 1'b0;
    got = 1'b0; d = '0; t = '0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.resp_valid) begin d = bus.resp_data; t = bus.resp_tag; got = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (got !== 1'b1 || d !== K1) begin errors++; $display("FAIL kupd_old_key: got valid=%b data=%h expected valid=1 data=%h", got, d, K1); end
    checks++; if (t !== 8'h31) begin errors++; $display("FAIL kupd_tag: got %h expected 31", t); end
    do_req(4'd1, 48'h0, 64'h0, 8'h32, d, t, e, lat);
    checks++; if (d !== K2) begin errors++; $display("FAIL kupd_new_key: got %h expected %h", d, K2); end
    write_key(4'd1, 64'h0, 1'b0, 1'b1);
    do_req(4'd1, 48'h0, 64'h77, 8'h33, d, t, e, lat);
    checks++; if (e !== 1'b1 || d !== 64'h0) begin errors++; $display("FAIL kinv_err: got err=%b data=%h expected err=1 data=0", e, d); end
    write_key(4'd3, K1, 1'b1, 1'b1);
    do_req(4'd3, 48'h0, 64'h0, 8'h34, d, t, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL kwe_inv_err: got %b expected 1", e); end
  endtask

  task automatic test_reset_midflight();
    logic [63:0] d; logic [7:0] t; logic e; int lat;
    int nresp;
    write_key(4'd1, K1, 1'b1, 1'b0);
    @(negedge clk);
    bus.resp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_asid = 4'd1;
    bus.req_addr = 48'h0; bus.req_data = 64'h0; bus.req_tag = 8'h51;
    @(negedge clk);
    bus.req_tag = 8'h52;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL rstmid_inflight: got %b expected 1", bus.resp_valid); end
    rst = 1'b1;
    #1;
    checks++; if (bus.resp_valid !== 1'b0 || bus.resp_data !== 64'h0) begin
      errors++; $display("FAIL rstmid_async_clear: got valid=%b data=%h expected valid=0 data=0", bus.resp_valid, bus.resp_data);
    end
    @(negedge clk);
    rst = 1'b0; bus.resp_ready = 1'b1;
    nresp = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (bus.resp_valid) nresp++;
    end
    checks++; if (nresp !== 0) begin errors++; $display("FAIL rstmid_no_resp: got %0d expected 0", nresp); end
    do_req(4'd1, 48'h0, 64'h0, 8'h53, d, t, e, lat);
    checks++; if (e !== 1'b1 || d !== 64'h0) begin errors++; $display("FAIL rstmid_keys_cleared: got err=%b data=%h expected err=1 data=0", e, d); end
  endtask

`ifdef SEV_ERR_CNT_EN
  task automatic test_err_cnt();
    logic [63:0] d; logic [7:0] t; logic e; int lat;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL errcnt_reset: got %0d expected 0", err_cnt); end
    for (int i = 0; i < 3; i++) do_req(4'd2, 48'h0, 64'h1, 8'(8'h60 + i), d, t, e, lat);
    @(negedge clk); #1;
    checks++; if (err_cnt !== 16'd3) begin errors++; $display("FAIL errcnt_three: got %0d expected 3", err_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_encrypt();
    test_involution();
    test_host_err();
    test_back_to_back();
    test_key_update();
    test_reset_midflight();
`ifdef SEV_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
